// File: rtl/microwave_cook_timer_pkg.sv
// microwave_pkg: state encodings, the state type and the default counter width
// shared by the cook timer, its bus interface and the testbench.
// Ports: none (package).
// Optional feature macro used elsewhere in this slice: MICROWAVE_BEEP_EN.
package microwave_pkg;

    localparam int COOK_TIME_W = 10;

    typedef logic [2:0] cook_state_t;

    localparam cook_state_t COOK_IDLE   = 3'd0;
    localparam cook_state_t COOK_LOADED = 3'd1;
    localparam cook_state_t COOK_RUN    = 3'd2;
    localparam cook_state_t COOK_PAUSE  = 3'd3;
    localparam cook_state_t COOK_DONE   = 3'd4;

endpackage

// File: rtl/microwave_cook_timer_if.sv
// microwave_cook_timer_if: cook handshake and panel bus between the oven
// controller (master) and the cook timer (slave).
// Signals:
//   cancel, load, time_val, heat_req, door_closed : controller -> timer
//   done, heater_on, remaining, timer_state        : timer -> controller
//   beep                                           : timer -> controller,
//                                                    only with MICROWAVE_BEEP_EN
interface microwave_cook_timer_if
    import microwave_pkg::*;
#(
    parameter int TIME_W = COOK_TIME_W
);
    logic              cancel;
    logic              load;
    logic [TIME_W-1:0] time_val;
    logic              heat_req;
    logic              door_closed;
    logic              done;
    logic              heater_on;
    logic [TIME_W-1:0] remaining;
    cook_state_t       timer_state;
`ifdef MICROWAVE_BEEP_EN
    logic              beep;
`endif

    modport master (
        output cancel, load, time_val, heat_req, door_closed,
        input  done, heater_on, remaining, timer_state
`ifdef MICROWAVE_BEEP_EN
        , input beep
`endif
    );

    modport slave (
        input  cancel, load, time_val, heat_req, door_closed,
        output done, heater_on, remaining, timer_state
`ifdef MICROWAVE_BEEP_EN
        , output beep
`endif
    );

endinterface

// File: rtl/microwave_cook_timer_prescaler.sv
// cook_prescaler: divides clk down to a 1-second tick for the cook timer.
// Ports:
//   clk        system clock
//   sys_reset  synchronous active-high reset
//   clr        return the count to zero (has priority over en)
//   en         advance the count this cycle
//   tick       1-cycle pulse in the enabled cycle where the count wraps
module cook_prescaler #(
    parameter int TICK_DIV = 100
) (
    input  logic clk,
    input  logic sys_reset,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // tick is combinational so the timer decrements on the same edge as the wrap.
    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (sys_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/microwave_cook_timer.sv
// microwave_cook_timer: responder side of the oven cook handshake. Holds the
// programmed cook time, drives the heater while cooking, counts down in
// 1-second ticks and raises done until the controller drops heat_req.
// Ports:
//   clk        system clock
//   sys_reset  synchronous active-high reset
//   bus        microwave_cook_timer_if.slave (panel inputs, handshake, status)
// Optional feature: MICROWAVE_BEEP_EN adds bus.beep and parameter BEEP_CYCLES.
//
// state  | meaning
// IDLE   | no cook time held
// LOADED | time held, waiting for heat_req & door_closed
// RUN    | heating, prescaler advancing
// PAUSE  | door open or heat_req dropped mid-cook, prescaler frozen
// DONE   | cook complete, done held until heat_req drops
module microwave_cook_timer
    import microwave_pkg::*;
#(
    parameter int TICK_DIV = 100,
    parameter int TIME_W   = COOK_TIME_W
`ifdef MICROWAVE_BEEP_EN
    , parameter int BEEP_CYCLES = 50
`endif
) (
    input  logic                   clk,
    input  logic                   sys_reset,
    microwave_cook_timer_if.slave  bus
);

    cook_state_t       state_q, state_d;
    logic [TIME_W-1:0] remaining_q, remaining_d;
    logic              done_q, done_d;
    logic              heater_on_q, heater_on_d;
    logic              go;
    logic              load_nz;
    logic              presc_clr;
    logic              presc_en;
    logic              tick;

    assign go       = bus.heat_req & bus.door_closed;
    assign load_nz  = bus.load & (bus.time_val != '0);
    assign presc_en = (state_q == COOK_RUN) & go;
    // A load in LOADED takes precedence over starting, so only clear on a real start.
    assign presc_clr = bus.cancel | ((state_q == COOK_LOADED) & ~bus.load & go);

    cook_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk       (clk),
        .sys_reset (sys_reset),
        .clr       (presc_clr),
        .en        (presc_en),
        .tick      (tick)
    );

    always_ff @(posedge clk) begin
        if (sys_reset) begin
            state_q     <= COOK_IDLE;
            remaining_q <= '0;
            done_q      <= 1'b0;
            heater_on_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            done_q      <= done_d;
            heater_on_q <= heater_on_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.cancel) begin
            state_d = COOK_IDLE;
        end else begin
            case (state_q)
                COOK_IDLE: begin
                    if (load_nz) state_d = COOK_LOADED;
                end
                COOK_LOADED: begin
                    if (bus.load)  state_d = load_nz ? COOK_LOADED : COOK_IDLE;
                    else if (go)   state_d = COOK_RUN;
                end
                COOK_RUN: begin
                    // Losing go pre-empts even the final tick.
                    if (!go)                                         state_d = COOK_PAUSE;
                    else if (tick && (remaining_q <= TIME_W'(1)))    state_d = COOK_DONE;
                end
                COOK_PAUSE: begin
                    if (go) state_d = COOK_RUN;
                end
                COOK_DONE: begin
                    if (!bus.heat_req) state_d = COOK_IDLE;
                end
                default: state_d = COOK_IDLE;
            endcase
        end
    end

    always_comb begin
        remaining_d = remaining_q;
        if (bus.cancel) begin
            remaining_d = '0;
        end else begin
            case (state_q)
                COOK_IDLE: begin
                    if (load_nz) remaining_d = bus.time_val;
                end
                COOK_LOADED: begin
                    if (bus.load) remaining_d = bus.time_val;
                end
                COOK_RUN: begin
                    if (go && tick && (remaining_q != '0)) remaining_d = remaining_q - TIME_W'(1);
                end
                COOK_PAUSE, COOK_DONE: remaining_d = remaining_q;
                default: remaining_d = '0;
            endcase
        end
        done_d      = (state_d == COOK_DONE);
        heater_on_d = (state_d == COOK_RUN);
    end

    assign bus.done        = done_q;
    assign bus.heater_on   = heater_on_q;
    assign bus.remaining   = remaining_q;
    assign bus.timer_state = state_q;

`ifdef MICROWAVE_BEEP_EN
    localparam int BEEP_W = $clog2(BEEP_CYCLES + 1);

    logic [BEEP_W-1:0] beep_cnt_q, beep_cnt_d;

    // Loaded on the edge that enters DONE; leaving DONE does not stop it.
    always_comb begin
        beep_cnt_d = beep_cnt_q;
        if (bus.cancel) begin
            beep_cnt_d = '0;
        end else if ((state_d == COOK_DONE) && (state_q != COOK_DONE)) begin
            beep_cnt_d = BEEP_W'(BEEP_CYCLES);
        end else if (beep_cnt_q != '0) begin
            beep_cnt_d = beep_cnt_q - BEEP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (sys_reset) begin
            beep_cnt_q <= '0;
        end else begin
            beep_cnt_q <= beep_cnt_d;
        end
    end

    assign bus.beep = (beep_cnt_q != '0);
`endif

endmodule

// File: tb/tb_microwave_cook_timer.sv
// tb_microwave_cook_timer: directed scenarios plus randomized panel/door/handshake
// traffic, checked every cycle against a reference model that tracks the cook as
// "heating cycles accumulated" against the programmed time.
// Ports: none. Honors MICROWAVE_BEEP_EN (BEEP_CYCLES = 3).
module tb_microwave_cook_timer;
    import microwave_pkg::*;

    localparam int TICK_DIV    = 4;
    localparam int TIME_W      = 10;
    localparam int BEEP_CYCLES = 3;

    logic clk;
    logic sys_reset;

    microwave_cook_timer_if #(.TIME_W(TIME_W)) bus ();

    microwave_cook_timer #(
        .TICK_DIV (TICK_DIV),
        .TIME_W   (TIME_W)
`ifdef MICROWAVE_BEEP_EN
        , .BEEP_CYCLES (BEEP_CYCLES)
`endif
    ) dut (
        .clk       (clk),
        .sys_reset (sys_reset),
        .bus       (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: phase 0 idle, 1 loaded, 2 heating, 3 paused, 4 done.
    int m_st;
    int m_time;
    int m_heated;
    int m_beep;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit go;
        go = bus.heat_req && bus.door_closed;
        if (sys_reset || bus.cancel) begin
            m_st = 0; m_time = 0; m_heated = 0; m_beep = 0;
        end else begin
            if (m_beep > 0) m_beep--;
            case (m_st)
                0: if (bus.load && bus.time_val != 0) begin
                       m_st = 1; m_time = int'(bus.time_val); m_heated = 0;
                   end
                1: if (bus.load) begin
                       m_time = int'(bus.time_val);
                       if (bus.time_val == 0) m_st = 0;
                   end else if (go) begin
                       m_st = 2; m_heated = 0;
                   end
                2: if (!go) m_st = 3;
                   else begin
                       m_heated++;
                       if (m_heated == m_time * TICK_DIV) begin
                           m_st = 4; m_beep = BEEP_CYCLES;
                       end
                   end
                3: if (go) m_st = 2;
                4: if (!bus.heat_req) begin
                       m_st = 0; m_time = 0; m_heated = 0;
                   end
                default: m_st = 0;
            endcase
        end
    endtask

    task automatic compare_model();
        chk("state",     32'(bus.timer_state), 32'(m_st));
        chk("remaining", 32'(bus.remaining),   32'(m_time - m_heated / TICK_DIV));
        chk("done",      32'(bus.done),        32'(m_st == 4));
        chk("heater_on", 32'(bus.heater_on),   32'(m_st == 2));
`ifdef MICROWAVE_BEEP_EN
        chk("beep",      32'(bus.beep),        32'(m_beep > 0));
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        compare_model();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load_time(input int t);
        bus.load = 1'b1; bus.time_val = TIME_W'(t);
        step();
        bus.load = 1'b0;
    endtask

    initial begin
        sys_reset = 1'b1;
        bus.cancel = 1'b0; bus.load = 1'b0; bus.time_val = '0;
        bus.heat_req = 1'b0; bus.door_closed = 1'b0;
        step();
        sys_reset = 1'b0;
        chk("reset_state", 32'(bus.timer_state), 0);
        chk("reset_remaining", 32'(bus.remaining), 0);
        chk("reset_done", 32'(bus.done), 0);
        chk("reset_heater", 32'(bus.heater_on), 0);

        // Normal cook of 3 s.
        load_time(3);
        chk("s1_loaded_rem", 32'(bus.remaining), 3);
        bus.heat_req = 1'b1; bus.door_closed = 1'b1;
        step();
        chk("s1_heater_on", 32'(bus.heater_on), 1);
        steps(4);
        chk("s1_rem_after4", 32'(bus.remaining), 2);
        steps(4);
        chk("s1_rem_after8", 32'(bus.remaining), 1);
        steps(4);
        chk("s1_rem_after12", 32'(bus.remaining), 0);
        chk("s1_done", 32'(bus.done), 1);
        chk("s1_heater_off", 32'(bus.heater_on), 0);
`ifdef MICROWAVE_BEEP_EN
        chk("s6_beep_c1", 32'(bus.beep), 1);
`endif
        bus.heat_req = 1'b0;
        step();
        chk("s1_idle", 32'(bus.timer_state), 0);
        chk("s1_done_clear", 32'(bus.done), 0);
`ifdef MICROWAVE_BEEP_EN
        chk("s6_beep_c2", 32'(bus.beep), 1);
        step();
        chk("s6_beep_c3", 32'(bus.beep), 1);
        step();
        chk("s6_beep_end", 32'(bus.beep), 0);
`endif

        // Door pause mid-cook.
        load_time(2);
        bus.heat_req = 1'b1; bus.door_closed = 1'b1;
        step();
        steps(6);
        chk("s2_rem_before_pause", 32'(bus.remaining), 1);
        bus.door_closed = 1'b0;
        step();
        chk("s2_pause", 32'(bus.timer_state), 3);
        chk("s2_pause_rem", 32'(bus.remaining), 1);
        chk("s2_pause_heater", 32'(bus.heater_on), 0);
        steps(4);
        bus.door_closed = 1'b1;
        step();
        chk("s2_resume", 32'(bus.timer_state), 2);
        step();
        chk("s2_not_done_yet", 32'(bus.done), 0);
        step();
        chk("s2_done", 32'(bus.done), 1);
        bus.heat_req = 1'b0;
        step();

        // Door opens on the final tick.
        load_time(1);
        bus.heat_req = 1'b1; bus.door_closed = 1'b1;
        step();
        steps(3);
        bus.door_closed = 1'b0;
        step();
        chk("s3_pause", 32'(bus.timer_state), 3);
        chk("s3_rem", 32'(bus.remaining), 1);
        chk("s3_no_done", 32'(bus.done), 0);
        bus.door_closed = 1'b1;
        step();
        step();
        chk("s3_done", 32'(bus.done), 1);
        bus.heat_req = 1'b0;
        step();

        // Cancel mid-cook wins over a simultaneous load.
        load_time(5);
        bus.heat_req = 1'b1;
        step();
        steps(9);
        bus.cancel = 1'b1; bus.load = 1'b1; bus.time_val = TIME_W'(7);
        step();
        bus.cancel = 1'b0; bus.load = 1'b0;
        chk("s4_idle", 32'(bus.timer_state), 0);
        chk("s4_rem", 32'(bus.remaining), 0);
        chk("s4_heater", 32'(bus.heater_on), 0);
        bus.heat_req = 1'b0;

        // Zero load ignored; reset during RUN.
        load_time(0);
        chk("s5_zero_load", 32'(bus.timer_state), 0);
        load_time(4);
        bus.heat_req = 1'b1;
        step();
        steps(5);
        sys_reset = 1'b1;
        step();
        sys_reset = 1'b0;
        chk("s5_rst_state", 32'(bus.timer_state), 0);
        chk("s5_rst_rem", 32'(bus.remaining), 0);
        chk("s5_rst_heater", 32'(bus.heater_on), 0);
        chk("s5_rst_done", 32'(bus.done), 0);

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            sys_reset  = ($urandom_range(0, 299) == 0);
            bus.cancel = ($urandom_range(0, 79) == 0);
            bus.load   = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 49) == 0) bus.time_val = TIME_W'($urandom_range(0, 1023));
            else                            bus.time_val = TIME_W'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) bus.heat_req    = ~bus.heat_req;
            if ($urandom_range(0, 24) == 0) bus.door_closed = ~bus.door_closed;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
